// File: rtl/parity_frame_rx_pkg.sv
// parity_frame_rx shared definitions.
// FSM state encodings and serial line levels.
package parity_frame_rx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/parity_frame_rx_acc.sv
// parity_acc: one-bit XOR accumulator.
// Clear wins over enable.
module parity_acc (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: start/data/parity/stop receiver.
// Acts on rx_in only when sample_en is high.
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  import parity_frame_rx_pkg::*;

  localparam int CW = $clog2(DATA_W) + 1;
  localparam int IW = CW - 1;
  localparam logic ODD = (ODD_PARITY != 0);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] word;
  logic              acc;
  logic              mism;
  logic              acc_clr;
  logic              acc_en;
  logic [IW-1:0]     idx;

  assign acc_clr = sample_en
                 && (state == ST_IDLE)
                 && (rx_in == START_LVL);
  assign acc_en  = sample_en
                 && (state == ST_DATA);
  assign idx     = cnt[IW-1:0];
  assign busy    = (state != ST_IDLE);

  parity_acc u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .d       (rx_in),
    .q       (acc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      word       <= '0;
      mism       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sample_en) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_in == START_LVL) begin
              state <= ST_DATA;
              cnt   <= '0;
              word  <= '0;
            end
          end
          ST_DATA: begin
            word[idx] <= rx_in;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            mism  <= rx_in ^ acc ^ ODD;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state      <= ST_IDLE;
            data_out   <= word;
            parity_err <= mism;
            frame_err  <= (rx_in != STOP_LVL);
            valid      <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: random and directed frames
// against a bit-queue reference model.
module tb_parity_frame_rx;

  import parity_frame_rx_pkg::*;

  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset_n;
  logic sample_en = 1'b0;
  logic rx_in = 1'b1;

  logic [DW-1:0] data0, data1;
  logic valid0, valid1;
  logic perr0, perr1;
  logic ferr0, ferr1;
  logic busy0, busy1;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(0)) dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .rx_in      (rx_in),
    .data_out   (data0),
    .valid      (valid0),
    .parity_err (perr0),
    .frame_err  (ferr0),
    .busy       (busy0)
  );

  parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(1)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .rx_in      (rx_in),
    .data_out   (data1),
    .valid      (valid1),
    .parity_err (perr1),
    .frame_err  (ferr1),
    .busy       (busy1)
  );

  function automatic void check(string nm,
                                logic [15:0] act,
                                logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  // Reference model: collect sampled bits from the
  // start bit on; a full frame is DW+3 bits.
  logic          q_bits[$];
  logic [DW-1:0] e_data  = '0;
  logic          e_valid = 1'b0;
  logic          e_p0    = 1'b0;
  logic          e_p1    = 1'b0;
  logic          e_fe    = 1'b0;
  logic          e_busy  = 1'b0;

  always @(posedge clock or negedge reset_n) begin : model
    logic [DW-1:0] w;
    logic          mis;
    if (!reset_n) begin
      q_bits.delete();
      e_data  <= '0;
      e_valid <= 1'b0;
      e_p0    <= 1'b0;
      e_p1    <= 1'b0;
      e_fe    <= 1'b0;
      e_busy  <= 1'b0;
    end else begin
      e_valid <= 1'b0;
      if (sample_en) begin
        if (q_bits.size() != 0 || rx_in == 1'b0)
          q_bits.push_back(rx_in);
        if (q_bits.size() == DW + 3) begin
          w = '0;
          for (int i = 0; i < DW; i++)
            w[i] = q_bits[i+1];
          mis = (^w) ^ q_bits[DW+1];
          e_data  <= w;
          e_p0    <= mis;
          e_p1    <= ~mis;
          e_fe    <= (q_bits[DW+2] == 1'b0);
          e_valid <= 1'b1;
          q_bits.delete();
        end
      end
      e_busy <= (q_bits.size() != 0);
    end
  end

  always @(negedge clock) begin
    check("data0",  16'(data0),  16'(e_data));
    check("data1",  16'(data1),  16'(e_data));
    check("valid0", 16'(valid0), 16'(e_valid));
    check("valid1", 16'(valid1), 16'(e_valid));
    check("perr0",  16'(perr0),  16'(e_p0));
    check("perr1",  16'(perr1),  16'(e_p1));
    check("ferr0",  16'(ferr0),  16'(e_fe));
    check("ferr1",  16'(ferr1),  16'(e_fe));
    check("busy0",  16'(busy0),  16'(e_busy));
    check("busy1",  16'(busy1),  16'(e_busy));
  end

  // Completed frames as seen on the DUT outputs.
  logic [10:0] got[$];

  always @(negedge clock) begin
    if (valid0 === 1'b1)
      got.push_back({data0, perr0, perr1, ferr0});
  end

  task automatic send_bit(input logic b, input int g);
    @(negedge clock);
    rx_in     = b;
    sample_en = 1'b1;
    repeat (g) begin
      @(negedge clock);
      sample_en = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d,
                            input logic p,
                            input logic s,
                            input int gmin,
                            input int gmax);
    send_bit(START_LVL, $urandom_range(gmax, gmin));
    for (int i = 0; i < DW; i++)
      send_bit(d[i], $urandom_range(gmax, gmin));
    send_bit(p, $urandom_range(gmax, gmin));
    send_bit(s, $urandom_range(gmax, gmin));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_in     = IDLE_LVL;
      sample_en = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic pop_check(input string nm,
                           input logic [DW-1:0] d,
                           input logic p0,
                           input logic p1,
                           input logic fe);
    logic [10:0] f;
    check({nm, "_seen"}, 16'(got.size() != 0), 16'd1);
    if (got.size() != 0) begin
      f = got.pop_front();
      check({nm, "_data"}, 16'(f[10:3]), 16'(d));
      check({nm, "_perr"}, 16'(f[2]), 16'(p0));
      check({nm, "_perr_odd"}, 16'(f[1]), 16'(p1));
      check({nm, "_ferr"}, 16'(f[0]), 16'(fe));
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          pb;
    logic          sb;
    int            nf;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data", 16'(data0), 16'd0);
    check("rst_valid", 16'(valid0), 16'd0);
    check("rst_busy", 16'(busy0), 16'd0);
    check("rst_flags", 16'({perr0, ferr0}), 16'd0);
    reset_n = 1'b1;

    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    idle(4);
    check("a5_count", 16'(got.size()), 16'd1);
    pop_check("a5", 8'hA5, 1'b0, 1'b1, 1'b0);

    send_frame(8'h01, 1'b0, 1'b1, 0, 1);
    idle(4);
    pop_check("x01", 8'h01, 1'b1, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
    idle(3);
    pop_check("x3c", 8'h3C, 1'b0, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1, 0, 0);
    idle(3);
    pop_check("x55", 8'h55, 1'b0, 1'b1, 1'b0);

    send_frame(8'h12, 1'b0, 1'b1, 1, 3);
    send_frame(8'h34, 1'b1, 1'b1, 1, 3);
    idle(4);
    check("b2b_count", 16'(got.size()), 16'd2);
    pop_check("b2b_12", 8'h12, 1'b0, 1'b1, 1'b0);
    pop_check("b2b_34", 8'h34, 1'b0, 1'b1, 1'b0);

    send_bit(START_LVL, 0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 0);
    @(negedge clock);
    sample_en = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("mid_rst_data", 16'(data0), 16'd0);
    check("mid_rst_busy", 16'(busy0), 16'd0);
    check("mid_rst_valid", 16'(valid0), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(4);
    check("mid_rst_novalid", 16'(got.size()), 16'd0);
    send_frame(8'h81, 1'b0, 1'b1, 0, 2);
    idle(4);
    pop_check("x81", 8'h81, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++)
      send_bit(1'b0, 0);
    @(negedge clock);
    sample_en = 1'b0;
    rx_in     = IDLE_LVL;
    idle(2);
    check("low_count", 16'(got.size()), 16'd1);
    pop_check("low", 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DW + 2; i++)
      send_bit(1'b1, 0);
    idle(4);
    got.delete();

    nf = 40;
    for (int k = 0; k < nf; k++) begin
      d  = DW'($urandom);
      pb = ($urandom_range(3, 0) == 0) ? ~(^d) : ^d;
      sb = ($urandom_range(4, 0) == 0) ? 1'b0 : 1'b1;
      send_frame(d, pb, sb, 0, 2);
      idle($urandom_range(3, 0));
    end
    idle(4);
    check("rand_count", 16'(got.size()), 16'(nf));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
